// File: rtl/edl_pkg.sv
// -----------------------------------------------------------------------------
// edl_pkg
// Shared types and helpers for the error-detecting stage controller.
//   state_e        : controller states (EMPTY, CHECK, FULL, RECOVER)
//   MODE_CORRECT   : replay the shadow sample after a mismatch
//   MODE_DETECT    : only flag mismatches, forward the main capture
//   lane_mismatch(): per-lane compare of two words, result bit i is set when
//                    any bit of lane i differs
// The helper works on fixed maximum-size vectors, so it supports WIDTH up to
// MAX_WIDTH and LANES up to MAX_LANES.
// -----------------------------------------------------------------------------
package edl_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    CHECK   = 2'd1,
    FULL    = 2'd2,
    RECOVER = 2'd3
  } state_e;

  localparam int MODE_CORRECT = 0;
  localparam int MODE_DETECT  = 1;

  localparam int MAX_WIDTH    = 256;
  localparam int MAX_WIDTH_LG = 8;
  localparam int MAX_LANES    = 32;
  localparam int MAX_LANES_LG = 5;

  // Lane i covers bits [i*width/lanes +: width/lanes]. Bits at or above
  // 'width' are ignored so callers can zero-extend freely.
  function automatic logic [MAX_LANES-1:0] lane_mismatch(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input int                   width,
    input int                   lanes
  );
    logic [MAX_LANES-1:0]    m;
    logic [MAX_LANES_LG-1:0] li;
    logic [MAX_WIDTH_LG-1:0] bx;
    int                      lane_w;
    m      = '0;
    lane_w = (lanes > 0) ? (width / lanes) : 1;
    if (lane_w == 0) lane_w = 1;
    for (int bi = 0; bi < MAX_WIDTH; bi++) begin
      bx = MAX_WIDTH_LG'(bi);
      li = MAX_LANES_LG'(bi / lane_w);
      if ((bi < width) && (a[bx] != b[bx])) m[li] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/edl_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// edl_stage_ctrl_if
// Data-path handshake bundle of one stage.
//   l_req / l_ack / l_data : upstream req/ack channel (main sample)
//   shadow_data            : late sample of l_data's net, valid the cycle
//                            after an upstream transfer
//   r_req / r_ack / r_data : downstream req/ack channel
// master = the environment (producer + consumer), slave = the stage.
// -----------------------------------------------------------------------------
interface edl_stage_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             l_req;
  logic             l_ack;
  logic [WIDTH-1:0] l_data;
  logic [WIDTH-1:0] shadow_data;
  logic             r_req;
  logic             r_ack;
  logic [WIDTH-1:0] r_data;

  modport master (
    output l_req, l_data, shadow_data, r_ack,
    input  l_ack, r_req, r_data
  );

  modport slave (
    input  l_req, l_data, shadow_data, r_ack,
    output l_ack, r_req, r_data
  );
endinterface

// File: rtl/edl_lane_cmp.sv
// -----------------------------------------------------------------------------
// edl_lane_cmp
// Per-lane comparator between the captured word and its shadow sample.
//   main_i   : captured register contents
//   shadow_i : late sample of the same net
//   en_i     : detection enable; 0 forces the result to all-zero
//   mism_o   : one bit per lane, set when any bit in that lane differs
// -----------------------------------------------------------------------------
module edl_lane_cmp
  import edl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic [WIDTH-1:0] main_i,
  input  logic [WIDTH-1:0] shadow_i,
  input  logic             en_i,
  output logic [LANES-1:0] mism_o
);

  logic [MAX_WIDTH-1:0] main_ext;
  logic [MAX_WIDTH-1:0] shadow_ext;
  logic [MAX_LANES-1:0] mism_all;

  always_comb begin
    main_ext               = '0;
    shadow_ext             = '0;
    main_ext[WIDTH-1:0]    = main_i;
    shadow_ext[WIDTH-1:0]  = shadow_i;
    mism_all               = lane_mismatch(main_ext, shadow_ext, WIDTH, LANES);
    mism_o                 = en_i ? mism_all[LANES-1:0] : '0;
  end

endmodule

// File: rtl/edl_stage_ctrl.sv
// -----------------------------------------------------------------------------
// edl_stage_ctrl
// Synchronous error-detecting bundled-data stage controller. Holds one
// WIDTH-bit pipeline register, checks it against a shadow sample taken one
// cycle later and either replays the shadow (MODE_CORRECT) or only flags the
// mismatch (MODE_DETECT).
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-low
//   bus        : handshake bundle (slave view): l_req/l_ack/l_data,
//                shadow_data, r_req/r_ack/r_data
//   err_en     : detection enable, only looked at in CHECK
//   err_clr    : clears err_count, wins over a same-cycle increment
//   sample     : main register loads this cycle
//   err_lane   : registered per-lane mismatch, one-cycle pulse
//   err_flag   : registered OR of err_lane
//   err_count  : saturating count of errored words
// -----------------------------------------------------------------------------
module edl_stage_ctrl
  import edl_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int LANES           = 4,
  parameter int RECOVERY_CYCLES = 1,
  parameter int MODE            = MODE_CORRECT,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  edl_stage_ctrl_if.slave      bus,
  input  logic                 err_en,
  input  logic                 err_clr,
  output logic                 sample,
  output logic [LANES-1:0]     err_lane,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count
);

  // The counter holds the remaining RECOVER cycles minus one; leaving on 0
  // gives exactly RECOVERY_CYCLES stall cycles.
  localparam logic [3:0]           RCNT_LOAD = 4'(RECOVERY_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = '1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [3:0]           rcnt_q, rcnt_d;
  logic                 r_req_q, r_req_d;
  logic [LANES-1:0]     err_lane_q, err_lane_d;
  logic                 err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [LANES-1:0]     mism;
  logic                 l_ack_c;
  logic                 load;

  edl_lane_cmp #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_cmp (
    .main_i   (data_q),
    .shadow_i (bus.shadow_data),
    .en_i     (err_en),
    .mism_o   (mism)
  );

  always_comb begin
    // l_ack is gated by rst so nothing is accepted while reset is held.
    l_ack_c     = rst & ((state_q == EMPTY) | ((state_q == FULL) & bus.r_ack));
    load        = bus.l_req & l_ack_c;
    state_d     = state_q;
    data_d      = data_q;
    rcnt_d      = rcnt_q;
    err_lane_d  = '0;
    err_flag_d  = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      EMPTY: begin
        if (load) begin
          data_d  = bus.l_data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_lane_d = mism;
        err_flag_d = |mism;
        if ((|mism) && (MODE == MODE_CORRECT)) begin
          data_d  = bus.shadow_data;
          rcnt_d  = RCNT_LOAD;
          state_d = RECOVER;
        end else begin
          state_d = FULL;
        end
      end
      RECOVER: begin
        if (rcnt_q == 4'd0) state_d = FULL;
        else                rcnt_d  = rcnt_q - 4'd1;
      end
      FULL: begin
        if (bus.r_ack) begin
          if (load) begin
            data_d  = bus.l_data;
            state_d = CHECK;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    if (err_clr) begin
      err_count_d = '0;
    end else if ((state_q == CHECK) && (|mism) && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    // r_req comes straight from a flop so it cannot glitch.
    r_req_d = (state_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      rcnt_q      <= '0;
      r_req_q     <= 1'b0;
      err_lane_q  <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rcnt_q      <= rcnt_d;
      r_req_q     <= r_req_d;
      err_lane_q  <= err_lane_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.l_ack  = l_ack_c;
  assign bus.r_req  = r_req_q;
  assign bus.r_data = data_q;
  assign sample     = load;
  assign err_lane   = err_lane_q;
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_edl_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_edl_stage_ctrl
// Three stage instances: dut0 corrects with a 2-cycle recovery, dut1 is
// detect-only, dut2 corrects with a 2-bit error counter. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_edl_stage_ctrl;
  import edl_pkg::*;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int mode_of [ND] = '{MODE_CORRECT, MODE_DETECT, MODE_CORRECT};
  int rc_of   [ND] = '{2, 1, 1};
  int cmax_of [ND] = '{65535, 65535, 3};

  logic [ND-1:0]        l_req_v, r_ack_v, en_v, clr_v;
  logic [ND-1:0][W-1:0] ldata_v, shd_v;
  logic [ND-1:0]        lack_v, rreq_v, smp_v, eflag_v;
  logic [ND-1:0][L-1:0] elane_v;
  logic [ND-1:0][W-1:0] rdata_v;
  logic [15:0]          cnt0, cnt1;
  logic [1:0]           cnt2;

  edl_stage_ctrl_if #(.WIDTH(W)) if0 ();
  edl_stage_ctrl_if #(.WIDTH(W)) if1 ();
  edl_stage_ctrl_if #(.WIDTH(W)) if2 ();

  assign if0.l_req = l_req_v[0];  assign if0.l_data = ldata_v[0];
  assign if0.shadow_data = shd_v[0];  assign if0.r_ack = r_ack_v[0];
  assign lack_v[0] = if0.l_ack;  assign rreq_v[0] = if0.r_req;  assign rdata_v[0] = if0.r_data;
  assign if1.l_req = l_req_v[1];  assign if1.l_data = ldata_v[1];
  assign if1.shadow_data = shd_v[1];  assign if1.r_ack = r_ack_v[1];
  assign lack_v[1] = if1.l_ack;  assign rreq_v[1] = if1.r_req;  assign rdata_v[1] = if1.r_data;
  assign if2.l_req = l_req_v[2];  assign if2.l_data = ldata_v[2];
  assign if2.shadow_data = shd_v[2];  assign if2.r_ack = r_ack_v[2];
  assign lack_v[2] = if2.l_ack;  assign rreq_v[2] = if2.r_req;  assign rdata_v[2] = if2.r_data;

  edl_stage_ctrl #(.WIDTH(W), .LANES(L), .RECOVERY_CYCLES(2), .MODE(MODE_CORRECT), .ERR_CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .err_en(en_v[0]), .err_clr(clr_v[0]),
    .sample(smp_v[0]), .err_lane(elane_v[0]), .err_flag(eflag_v[0]), .err_count(cnt0));
  edl_stage_ctrl #(.WIDTH(W), .LANES(L), .RECOVERY_CYCLES(1), .MODE(MODE_DETECT), .ERR_CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .err_en(en_v[1]), .err_clr(clr_v[1]),
    .sample(smp_v[1]), .err_lane(elane_v[1]), .err_flag(eflag_v[1]), .err_count(cnt1));
  edl_stage_ctrl #(.WIDTH(W), .LANES(L), .RECOVERY_CYCLES(1), .MODE(MODE_CORRECT), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2), .err_en(en_v[2]), .err_clr(clr_v[2]),
    .sample(smp_v[2]), .err_lane(elane_v[2]), .err_flag(eflag_v[2]), .err_count(cnt2));

  function automatic int cnt_of(input int d);
    if (d == 0) return int'(cnt0);
    if (d == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Pushes one word through an empty stage with r_ack held high and reports
  // what was observed; the calling test decides what is correct.
  task automatic xfer(input int d, input logic [W-1:0] w, input logic [W-1:0] s,
                      input logic en, input logic clr,
                      output logic smp0, output int lat, output logic [W-1:0] data,
                      output logic [L-1:0] lanes, output int pulses);
    lat = -1; data = '0; lanes = '0; pulses = 0;
    r_ack_v[d] = 1'b1; l_req_v[d] = 1'b1; ldata_v[d] = w;
    mid();
    smp0 = smp_v[d];
    tick();
    l_req_v[d] = 1'b0; ldata_v[d] = $urandom; shd_v[d] = s; en_v[d] = en; clr_v[d] = clr;
    mid();
    if (eflag_v[d]) pulses++;
    tick();
    shd_v[d] = $urandom; clr_v[d] = 1'b0;
    for (int c = 2; c < 40 && lat < 0; c++) begin
      mid();
      if (eflag_v[d]) pulses++;
      lanes |= elane_v[d];
      if (rreq_v[d]) begin
        lat  = c;
        data = rdata_v[d];
      end
      tick();
    end
    mid();
    if (eflag_v[d]) pulses++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    l_req_v = '1; r_ack_v = '0; en_v = '1; clr_v = '0; ldata_v = '0; shd_v = '0;
    tick();
    mid();
    for (int d = 0; d < ND; d++) begin
      checks++; if (lack_v[d] !== 1'b0) $display("FAIL reset.l_ack[%0d]: got %b want 0", d, lack_v[d]); else passed++;
      checks++; if (smp_v[d] !== 1'b0) $display("FAIL reset.sample[%0d]: got %b want 0", d, smp_v[d]); else passed++;
      checks++; if (rreq_v[d] !== 1'b0) $display("FAIL reset.r_req[%0d]: got %b want 0", d, rreq_v[d]); else passed++;
      checks++; if (rdata_v[d] !== '0) $display("FAIL reset.r_data[%0d]: got %h want 0", d, rdata_v[d]); else passed++;
      checks++; if (elane_v[d] !== '0) $display("FAIL reset.err_lane[%0d]: got %b want 0", d, elane_v[d]); else passed++;
      checks++; if (eflag_v[d] !== 1'b0) $display("FAIL reset.err_flag[%0d]: got %b want 0", d, eflag_v[d]); else passed++;
      checks++; if (cnt_of(d) !== 0) $display("FAIL reset.err_count[%0d]: got %0d want 0", d, cnt_of(d)); else passed++;
    end
    tick();
    rst = 1'b1; l_req_v = '0; r_ack_v = '1;
    mid();
    for (int d = 0; d < ND; d++) begin
      checks++; if (lack_v[d] !== 1'b1) $display("FAIL reset.l_ack_after[%0d]: got %b want 1", d, lack_v[d]); else passed++;
    end
    tick();
  endtask

  task automatic test_single();
    logic smp0; int lat; logic [W-1:0] data; logic [L-1:0] lanes; int pulses;
    xfer(0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0, smp0, lat, data, lanes, pulses);
    checks++; if (smp0 !== 1'b1) $display("FAIL single.sample: got %b want 1", smp0); else passed++;
    checks++; if (lat != 2) $display("FAIL single.latency: got %0d want 2", lat); else passed++;
    checks++; if (data !== 32'hA5A5A5A5) $display("FAIL single.r_data: got %h want a5a5a5a5", data); else passed++;
    checks++; if (pulses != 0) $display("FAIL single.err_flag_cycles: got %0d want 0", pulses); else passed++;
    mid();
    checks++; if (cnt_of(0) != 0) $display("FAIL single.err_count: got %0d want 0", cnt_of(0)); else passed++;
    tick();
  endtask

  task automatic test_correct();
    logic smp0; int lat; logic [W-1:0] data; logic [L-1:0] lanes; int pulses;
    xfer(0, 32'h12345678, 32'h12345778, 1'b1, 1'b0, smp0, lat, data, lanes, pulses);
    checks++; if (lanes !== 4'b0010) $display("FAIL correct.err_lane: got %b want 0010", lanes); else passed++;
    checks++; if (pulses != 1) $display("FAIL correct.err_flag_cycles: got %0d want 1", pulses); else passed++;
    checks++; if (lat != 4) $display("FAIL correct.latency: got %0d want 4", lat); else passed++;
    checks++; if (data !== 32'h12345778) $display("FAIL correct.r_data: got %h want 12345778", data); else passed++;
    mid();
    checks++; if (cnt_of(0) != 1) $display("FAIL correct.err_count: got %0d want 1", cnt_of(0)); else passed++;
    tick();
  endtask

  task automatic test_detect();
    logic smp0; int lat; logic [W-1:0] data; logic [L-1:0] lanes; int pulses;
    xfer(1, 32'h12345678, 32'h12345778, 1'b1, 1'b0, smp0, lat, data, lanes, pulses);
    checks++; if (lanes !== 4'b0010) $display("FAIL detect.err_lane: got %b want 0010", lanes); else passed++;
    checks++; if (pulses != 1) $display("FAIL detect.err_flag_cycles: got %0d want 1", pulses); else passed++;
    checks++; if (lat != 2) $display("FAIL detect.latency: got %0d want 2", lat); else passed++;
    checks++; if (data !== 32'h12345678) $display("FAIL detect.r_data: got %h want 12345678", data); else passed++;
    mid();
    checks++; if (cnt_of(1) != 1) $display("FAIL detect.err_count: got %0d want 1", cnt_of(1)); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1, w2;
    w1 = $urandom; w2 = $urandom;
    r_ack_v[0] = 1'b0; l_req_v[0] = 1'b1; ldata_v[0] = w1; en_v[0] = 1'b1;
    tick();
    l_req_v[0] = 1'b0; shd_v[0] = w1;
    tick();
    for (int k = 0; k < 5; k++) begin
      l_req_v[0] = 1'b1; ldata_v[0] = w2; shd_v[0] = $urandom;
      mid();
      checks++; if (rreq_v[0] !== 1'b1) $display("FAIL bp%0d.r_req: got %b want 1", k, rreq_v[0]); else passed++;
      checks++; if (rdata_v[0] !== w1) $display("FAIL bp%0d.r_data: got %h want %h", k, rdata_v[0], w1); else passed++;
      checks++; if (lack_v[0] !== 1'b0) $display("FAIL bp%0d.l_ack: got %b want 0", k, lack_v[0]); else passed++;
      tick();
    end
    r_ack_v[0] = 1'b1;
    mid();
    checks++; if (lack_v[0] !== 1'b1) $display("FAIL b2b.l_ack: got %b want 1", lack_v[0]); else passed++;
    checks++; if (smp_v[0] !== 1'b1) $display("FAIL b2b.sample: got %b want 1", smp_v[0]); else passed++;
    tick();
    l_req_v[0] = 1'b0; shd_v[0] = w2;
    mid();
    checks++; if (rreq_v[0] !== 1'b0) $display("FAIL b2b.check_r_req: got %b want 0", rreq_v[0]); else passed++;
    checks++; if (lack_v[0] !== 1'b0) $display("FAIL b2b.check_l_ack: got %b want 0", lack_v[0]); else passed++;
    tick();
    mid();
    checks++; if (rdata_v[0] !== w2 || rreq_v[0] !== 1'b1) $display("FAIL b2b.second: got r_req=%b r_data=%h want 1 %h", rreq_v[0], rdata_v[0], w2); else passed++;
    tick();
  endtask

  task automatic test_counter_sat();
    logic smp0; int lat; logic [W-1:0] data, w, s; logic [L-1:0] lanes; int pulses; int expc;
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      s = w ^ (32'h1 << ($urandom_range(31, 0)));
      xfer(2, w, s, 1'b1, 1'b0, smp0, lat, data, lanes, pulses);
      expc = (k + 1 > 3) ? 3 : k + 1;
      mid();
      checks++; if (cnt_of(2) != expc) $display("FAIL sat%0d.err_count: got %0d want %0d", k, cnt_of(2), expc); else passed++;
      tick();
    end
  endtask

  task automatic test_clr();
    logic smp0; int lat; logic [W-1:0] data; logic [L-1:0] lanes; int pulses;
    xfer(2, 32'h0F0F0F0F, 32'h8F0F0F0F, 1'b1, 1'b1, smp0, lat, data, lanes, pulses);
    checks++; if (pulses != 1) $display("FAIL clr.err_flag_cycles: got %0d want 1", pulses); else passed++;
    checks++; if (data !== 32'h8F0F0F0F) $display("FAIL clr.r_data: got %h want 8f0f0f0f", data); else passed++;
    mid();
    checks++; if (cnt_of(2) != 0) $display("FAIL clr.err_count: got %0d want 0", cnt_of(2)); else passed++;
    tick();
  endtask

  task automatic test_err_en_off();
    logic smp0; int lat; logic [W-1:0] data; logic [L-1:0] lanes; int pulses;
    xfer(0, 32'hCAFEF00D, 32'h35011FF2, 1'b0, 1'b0, smp0, lat, data, lanes, pulses);
    checks++; if (pulses != 0) $display("FAIL en_off.err_flag_cycles: got %0d want 0", pulses); else passed++;
    checks++; if (lat != 2) $display("FAIL en_off.latency: got %0d want 2", lat); else passed++;
    checks++; if (data !== 32'hCAFEF00D) $display("FAIL en_off.r_data: got %h want cafef00d", data); else passed++;
    mid();
    checks++; if (cnt_of(0) != 1) $display("FAIL en_off.err_count: got %0d want 1", cnt_of(0)); else passed++;
    tick();
  endtask

  task automatic test_reset_recover();
    r_ack_v[0] = 1'b1; l_req_v[0] = 1'b1; ldata_v[0] = 32'h11112222; en_v[0] = 1'b1;
    tick();
    l_req_v[0] = 1'b0; shd_v[0] = 32'h11112223;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mid();
    checks++; if (rreq_v[0] !== 1'b0) $display("FAIL rst_rec.r_req: got %b want 0", rreq_v[0]); else passed++;
    checks++; if (lack_v[0] !== 1'b1) $display("FAIL rst_rec.l_ack: got %b want 1", lack_v[0]); else passed++;
    checks++; if (cnt_of(0) != 0) $display("FAIL rst_rec.err_count: got %0d want 0", cnt_of(0)); else passed++;
    checks++; if (eflag_v[0] !== 1'b0) $display("FAIL rst_rec.err_flag: got %b want 0", eflag_v[0]); else passed++;
    tick();
    for (int k = 0; k < 4; k++) begin
      mid();
      checks++; if (rreq_v[0] !== 1'b0) $display("FAIL rst_rec.discard%0d r_req: got %b want 0", k, rreq_v[0]); else passed++;
      tick();
    end
  endtask

  // Transaction-timeline model: an accepted word becomes visible 2 cycles
  // later, plus the recovery stall when it gets corrected; the stage is busy
  // from acceptance until the downstream transfer.
  task automatic test_random(input int d, input int ncyc);
    bit have; int t_acc, ready_at, cnt_m; bit inc_p, clr_p;
    logic [W-1:0] w_cur, exp_out, flip; logic [L-1:0] m, lexp;
    logic [L-1:0] lane_exp [int];
    logic exp_rreq, exp_lack, exp_smp;
    have = 0; t_acc = -10; ready_at = 0; cnt_m = cnt_of(d) == 0 ? 0 : 0;
    inc_p = 0; clr_p = 0; w_cur = '0; exp_out = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (clr_p) cnt_m = 0;
      else if (inc_p && cnt_m < cmax_of[d]) cnt_m++;
      inc_p = 0;
      l_req_v[d] = ($urandom_range(3, 0) != 0);
      ldata_v[d] = $urandom;
      r_ack_v[d] = ($urandom_range(2, 0) != 0);
      clr_v[d]   = ($urandom_range(15, 0) == 0);
      en_v[d]    = ($urandom_range(3, 0) != 0);
      shd_v[d]   = $urandom;
      if (have && c == t_acc + 1) begin
        flip = '0;
        for (int i = 0; i < L; i++)
          if ($urandom_range(2, 0) == 0) flip[8*i + $urandom_range(7, 0)] = 1'b1;
        shd_v[d] = w_cur ^ flip;
        m = '0;
        for (int i = 0; i < L; i++)
          if (en_v[d] && (w_cur[8*i +: 8] != shd_v[d][8*i +: 8])) m[i] = 1'b1;
        inc_p = (m != '0);
        lane_exp[c + 1] = m;
        exp_out  = ((m != '0) && mode_of[d] == MODE_CORRECT) ? shd_v[d] : w_cur;
        ready_at = c + 1 + (((m != '0) && mode_of[d] == MODE_CORRECT) ? rc_of[d] : 0);
      end
      clr_p = clr_v[d];
      exp_rreq = have && (c >= ready_at);
      exp_lack = !have || (exp_rreq && r_ack_v[d]);
      exp_smp  = l_req_v[d] && exp_lack;
      lexp = lane_exp.exists(c) ? lane_exp[c] : '0;
      mid();
      checks++; if (smp_v[d] !== exp_smp) $display("FAIL rnd%0d.c%0d sample: got %b want %b", d, c, smp_v[d], exp_smp); else passed++;
      checks++; if (lack_v[d] !== exp_lack) $display("FAIL rnd%0d.c%0d l_ack: got %b want %b", d, c, lack_v[d], exp_lack); else passed++;
      checks++; if (rreq_v[d] !== exp_rreq) $display("FAIL rnd%0d.c%0d r_req: got %b want %b", d, c, rreq_v[d], exp_rreq); else passed++;
      if (exp_rreq) begin
        checks++; if (rdata_v[d] !== exp_out) $display("FAIL rnd%0d.c%0d r_data: got %h want %h", d, c, rdata_v[d], exp_out); else passed++;
      end
      checks++; if (elane_v[d] !== lexp) $display("FAIL rnd%0d.c%0d err_lane: got %b want %b", d, c, elane_v[d], lexp); else passed++;
      checks++; if (eflag_v[d] !== (lexp != '0)) $display("FAIL rnd%0d.c%0d err_flag: got %b want %b", d, c, eflag_v[d], (lexp != '0)); else passed++;
      checks++; if (cnt_of(d) != cnt_m) $display("FAIL rnd%0d.c%0d err_count: got %0d want %0d", d, c, cnt_of(d), cnt_m); else passed++;
      if (exp_rreq && r_ack_v[d]) have = 0;
      if (exp_smp) begin
        have = 1; t_acc = c; w_cur = ldata_v[d]; ready_at = c + 1000;
      end
      tick();
    end
    l_req_v[d] = 1'b0; clr_v[d] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_correct();
    test_detect();
    test_back_to_back();
    test_counter_sat();
    test_clr();
    test_err_en_off();
    test_reset_recover();
    for (int d = 0; d < ND; d++) test_random(d, 250);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
